lsu_mem_ctrl: RTL and testbench

Load/store controller in the MEM stage. It is the initiator side of the word-wide, synchronous-read data memory port.
- Accepts one RV32I load or store per request from the pipeline.
- Converts the byte address to a word index and checks alignment and range.
- Performs read-modify-write for SB/SH, because the memory has no byte enables.
- Returns sign- or zero-extended load data, and back-pressures the pipeline through `req_ready`.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_align.sv | 51 +++++
 rtl/lsu_mem_ctrl.sv | 110 +++++++++++
 tb/tb_lsu_mem_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes and FSM state encoding.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      LDONE = 3'd3,
      MERGE = 3'd4,
      ERR   = 3'd5
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: extends load data from a memory word and merges sub-word
// store data into a read word (the memory has no byte enables).
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   input  logic [31:0] store_data,
   output logic [31:0] load_value,
   output logic [31:0] merged_word
);

   logic [31:0] shifted;
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   always_comb begin
      shifted  = word >> {offset, 3'b000};
      sel_byte = shifted[7:0];
      sel_half = offset[1] ? word[31:16] : word[15:0];

      load_value = 32'd0;
      case (funct3)
         F3_B:    load_value = {{24{sel_byte[7]}}, sel_byte};
         F3_H:    load_value = {{16{sel_half[15]}}, sel_half};
         F3_W:    load_value = word;
         F3_BU:   load_value = {24'd0, sel_byte};
         F3_HU:   load_value = {16'd0, sel_half};
         default: load_value = 32'd0;
      endcase

      merged_word = word;
      case (funct3[1:0])
         2'b00: begin
            case (offset)
               2'd0:    merged_word[7:0]   = store_data[7:0];
               2'd1:    merged_word[15:8]  = store_data[7:0];
               2'd2:    merged_word[23:16] = store_data[7:0];
               default: merged_word[31:24] = store_data[7:0];
            endcase
         end
         2'b01: begin
            if (offset[1]) merged_word[31:16] = store_data[15:0];
            else           merged_word[15:0]  = store_data[15:0];
         end
         default: merged_word = store_data;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller driving a word-wide synchronous-read data memory.
// Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_store,
   input  logic [2:0]            req_funct3,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [31:0]           resp_rdata,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic                  mem_re,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata
);

   state_t                state, state_next;
   logic [2:0]            funct3_q;
   logic [1:0]            offset_q;
   logic [ADDR_WIDTH-1:0] index_q;
   logic [31:0]           wdata_q;
   logic                  store_q;

   logic        misaligned, out_of_range, illegal, accept;
   logic [31:0] load_value, merged_word;

   assign accept = (state == IDLE) && req_valid;

   always_comb begin
      misaligned   = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0])
                   || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
      out_of_range = |req_addr[31:ADDR_WIDTH+2];
      if (req_store) illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
      else           illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         funct3_q <= 3'd0;
         offset_q <= 2'd0;
         index_q  <= '0;
         wdata_q  <= 32'd0;
         store_q  <= 1'b0;
      end else if (accept) begin
         funct3_q <= req_funct3;
         offset_q <= req_addr[1:0];
         index_q  <= req_addr[ADDR_WIDTH+1:2];
         wdata_q  <= req_wdata;
         store_q  <= req_store;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (illegal || misaligned || out_of_range) state_next = ERR;
               else if (req_store && (req_funct3 == F3_W)) state_next = WRITE;
               else                                        state_next = READ;
            end
         end
         READ:    state_next = store_q ? MERGE : LDONE;
         WRITE,
         LDONE,
         MERGE,
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   lsu_align u_align (
      .funct3      (funct3_q),
      .offset      (offset_q),
      .word        (mem_rdata),
      .store_data  (wdata_q),
      .load_value  (load_value),
      .merged_word (merged_word)
   );

   // Outputs decode straight from state so an asynchronous reset clears them at once.
   always_comb begin
      req_ready  = (state == IDLE);
      mem_addr   = index_q;
      mem_we     = (state == WRITE) || (state == MERGE);
      mem_re     = (state == READ);
      mem_wdata  = 32'd0;
      resp_valid = (state == WRITE) || (state == LDONE) || (state == MERGE) || (state == ERR);
      resp_err   = (state == ERR);
      resp_rdata = 32'd0;
      if (state == WRITE) mem_wdata = wdata_q;
      if (state == MERGE) mem_wdata = merged_word;
      if (state == LDONE) resp_rdata = load_value;
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: driver issues requests, a monitor checks responses
// and memory writes against expected queues, plus a mid-MERGE reset scenario.
module tb_lsu_mem_ctrl;

   localparam int AW = 14;
   localparam int RW = 65;
   localparam int WW = AW + 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_store = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'd0;
   logic [31:0]   req_wdata = 32'd0;
   logic          resp_valid;
   logic          resp_err;
   logic [31:0]   resp_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic          mem_re;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata = 32'd0;

   logic [31:0]   mem [0:(1<<AW)-1];
   logic          preload_en = 1'b0;
   logic [31:0]   preload_val = 32'd0;

   logic [RW-1:0] exp_q[$];
   logic [WW-1:0] wexp_q[$];
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   int            rd_cnt = 0;
   int            rd_exp = 0;

   lsu_mem_ctrl #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_err   (resp_err),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // clock / memory model
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (preload_en) mem[4] <= preload_val;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // monitor / scoreboard
   logic [RW-1:0] e;
   logic [WW-1:0] w;
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we && mem_re) chk("we_re_exclusive", 64'd1, 64'd0);
         if (mem_re) rd_cnt++;
         if (resp_valid) begin
            if (exp_q.size() == 0) chk("unexpected_resp", 64'd1, 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("resp_cycle", 64'(cyc), 64'(e[64:33]));
               chk("resp_err", 64'(resp_err), 64'(e[32]));
               chk("resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
               if (resp_err) chk("err_no_mem_access", 64'({mem_we, mem_re}), 64'd0);
            end
         end
         if (mem_we) begin
            if (wexp_q.size() == 0) chk("unexpected_write", 64'(mem_addr), 64'hFFFF);
            else begin
               w = wexp_q.pop_front();
               chk("write_addr", 64'(mem_addr), 64'(w[WW-1:32]));
               chk("write_data", 64'(mem_wdata), 64'(w[31:0]));
            end
         end
      end
   end

   // driver tasks
   task automatic wait_ready();
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) chk("ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic e_err, input logic [31:0] e_rd,
                        input int lat, input logic e_we, input logic [31:0] e_w);
      logic [31:0] due;
      wait_ready();
      req_valid  = 1'b1;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      due = 32'(cyc + lat);
      exp_q.push_back({due, e_err, e_rd});
      if (e_we) wexp_q.push_back({a[AW+1:2], e_w});
      if (lat == 2) rd_exp++;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic preload(input logic [31:0] v);
      @(negedge clk);
      preload_val = v;
      preload_en  = 1'b1;
      @(posedge clk);
      #1 preload_en = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_outputs", 64'({mem_we, mem_re, resp_valid, resp_err}), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_data", 64'({mem_wdata, resp_rdata}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      preload(32'h8899AABB);

      issue(1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFFFF88, 2, 1'b0, 32'h0);
      issue(1'b0, 3'b100, 32'h13, 32'h0, 1'b0, 32'h00000088, 2, 1'b0, 32'h0);
      issue(1'b0, 3'b001, 32'h12, 32'h0, 1'b0, 32'hFFFF8899, 2, 1'b0, 32'h0);
      issue(1'b0, 3'b101, 32'h10, 32'h0, 1'b0, 32'h0000AABB, 2, 1'b0, 32'h0);
      issue(1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFFFFBB, 2, 1'b0, 32'h0);
      issue(1'b1, 3'b000, 32'h11, 32'h5A, 1'b0, 32'h0, 2, 1'b1, 32'h88995ABB);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h88995ABB, 2, 1'b0, 32'h0);
      issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1, 1'b1, 32'hDEADBEEF);
      issue(1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000DEAD, 2, 1'b0, 32'h0);
      issue(1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFFBEEF, 2, 1'b0, 32'h0);
      issue(1'b0, 3'b000, 32'h11, 32'h0, 1'b0, 32'hFFFFFFBE, 2, 1'b0, 32'h0);
      issue(1'b1, 3'b001, 32'h12, 32'h00007FFF, 1'b0, 32'h0, 2, 1'b1, 32'h7FFFBEEF);
      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h7FFFBEEF, 2, 1'b0, 32'h0);

      issue(1'b0, 3'b001, 32'h11, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0);
      issue(1'b1, 3'b010, 32'h12, 32'h11111111, 1'b1, 32'h0, 1, 1'b0, 32'h0);
      issue(1'b0, 3'b010, 32'h00010000, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0);
      issue(1'b0, 3'b011, 32'h10, 32'h0, 1'b1, 32'h0, 1, 1'b0, 32'h0);
      issue(1'b1, 3'b100, 32'h10, 32'h22222222, 1'b1, 32'h0, 1, 1'b0, 32'h0);

      // reset asserted during the MERGE cycle of SH 0x1234 at 0x10
      wait_ready();
      preload(32'h8899AABB);
      wait_ready();
      req_valid  = 1'b1;
      req_store  = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 32'h10;
      req_wdata  = 32'h00001234;
      rd_exp++;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("merge_we", 64'(mem_we), 64'd1);
      chk("merge_wdata", 64'(mem_wdata), 64'h88991234);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_drop_we", 64'({mem_we, mem_re, resp_valid}), 64'd0);
      chk("rst_drop_ready", 64'(req_ready), 64'd1);
      chk("rst_drop_addr", 64'(mem_addr), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("word4_kept", 64'(mem[4]), 64'h8899AABB);
      chk("ready_after_rst", 64'(req_ready), 64'd1);

      issue(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8899AABB, 2, 1'b0, 32'h0);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      chk("resp_queue_drained", 64'(exp_q.size()), 64'd0);
      chk("write_queue_drained", 64'(wexp_q.size()), 64'd0);
      chk("read_strobe_count", 64'(rd_cnt), 64'(rd_exp));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
